// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the serial pattern scanner: FSM state encodings and width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pattern_scan_pkg;

  // One-hot state encoding; any other value is treated as illegal and recovers to idle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pattern_shift_cmp.sv
// History shift register with saturating bit counter and length/don't-care masked compare.
// Latency: hit is combinational on the post-shift view of the sampling cycle.
// Backpressure: none; shifts only when shift is high, otherwise holds.
module pattern_shift_cmp
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = 8,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               d,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [MAX_LEN-1:0] mask,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   cnt_nxt;

  // Post-shift view: the compare sees the history including the bit being sampled now.
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], d};
    cnt_nxt  = (bit_cnt >= len) ? bit_cnt : bit_cnt + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    hit = shift && (cnt_nxt >= len) &&
          (((hist_nxt ^ pattern) & len_mask & ~mask) == '0);
  end

  // History is never flushed on a match, so overlapping occurrences are found naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      hist    <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      hist    <= hist_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Run-controlled serial pattern scanner: config regs, IDLE/RUN/DONE FSM, saturating match counter.
// Latency: match_o and match_cnt update one cycle after the sampling edge of the matching bit.
// Backpressure: none; bits are consumed whenever valid_i is high in RUN. Optional PATTERN_SCAN_MASK_EN adds cfg_mask.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
`ifdef PATTERN_SCAN_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic               start,
  input  logic               stop,
  input  logic               d_i,
  input  logic               valid_i,
  output logic               busy,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done
);

  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] mask_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   thresh_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               run;
  logic               cfg_ok;
  logic               start_ok;
  logic               hit;
  logic               final_hit;

  pattern_shift_cmp #(.MAX_LEN(MAX_LEN)) u_shift_cmp (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .shift   (run && valid_i),
    .d       (d_i),
    .pattern (pattern_q),
    .mask    (mask_q),
    .len     (len_q),
    .hit     (hit)
  );

  // Next-state, control decode and status outputs; a config write in the same cycle masks start.
  always_comb begin
    run       = (state == ST_RUN);
    cfg_ok    = (state == ST_IDLE) || (state == ST_DONE);
    start_ok  = start && !cfg_we && cfg_ok &&
                (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    cnt_inc   = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    final_hit = hit && (thresh_q != '0) && (cnt_inc == thresh_q);
    busy      = run;
    done      = (state == ST_DONE);
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_RUN;
      ST_RUN: begin
        if (final_hit)  state_nxt = ST_DONE;
        else if (stop)  state_nxt = ST_IDLE;
      end
      ST_DONE: if (start_ok) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Config is only writable while not scanning so a live compare never sees a half-changed pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      thresh_q  <= '0;
    end else if (cfg_we && cfg_ok) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      thresh_q  <= cfg_thresh;
`ifdef PATTERN_SCAN_MASK_EN
      mask_q    <= cfg_mask;
`else
      mask_q    <= '0;
`endif
    end
  end

  // Match pulse and saturating counter; count is cleared on every accepted start and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_o   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match_o <= run && hit;
      if (start_ok)       match_cnt <= '0;
      else if (run && hit) match_cnt <= cnt_inc;
    end
  end

endmodule
